// File: rtl/gth_tx_word_driver.sv
// gth_tx_word_driver: drives the 32-bit GTH TX user word stream.
// After the transceiver TX reset completes it sends a SYNC_WORD preamble. It then
// streams idle words, FIFO-buffered user words, a free-running count or PRBS-31.
// Build option: define TX_PRBS_EN to include the PRBS-31 generator. Without it,
// mode PRBS sends idle words.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// WAIT_DONE | TX reset not settled; idle words, FIFO flushed
// SYNC      | preamble: SYNC_WORD for SYNC_LEN words
// RUN       | mode-selected source on the wire, tx_active_o high
module gth_tx_word_driver #(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned SYNC_LEN   = 16,
   parameter logic [31:0] SYNC_WORD  = 32'hBC50_BC50,
   parameter logic [31:0] IDLE_WORD  = 32'h0000_BCBC
) (
   input  logic        TX_WORDCLK_i,
   input  logic        TX_RESET_N_i,
   input  logic        tx_reset_done_i,
   input  logic [1:0]  mode_i,
   input  logic [31:0] user_data_i,
   input  logic        user_valid_i,
   output logic        user_ready_o,
   output logic [31:0] USER_DATA_o,
   output logic        tx_active_o,
   output logic [6:0]  fifo_level_o,
   output logic [15:0] underrun_cnt_o
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [1:0] MODE_IDLE  = 2'd0;
   localparam logic [1:0] MODE_USER  = 2'd1;
   localparam logic [1:0] MODE_PRBS  = 2'd2;
   localparam logic [1:0] MODE_COUNT = 2'd3;

   typedef enum logic [1:0] {ST_WAIT_DONE, ST_SYNC, ST_RUN} state_t;

   state_t          state_q, state_nxt;
   logic            done_q;
   logic [1:0]      mode_q;
   logic [7:0]      sync_cnt_q;
   logic [31:0]     cnt_q;
   logic [31:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [6:0]      level_q, level_nxt;
   logic [15:0]     underrun_cnt_q;
   logic [31:0]     data_d;
   logic            active_d;

   logic mode_chg, flush, run_ok, push, pop, underrun;

   // A mode change in RUN gets one idle word while the preamble restarts.
   assign mode_chg = (state_q == ST_RUN) && (mode_i != mode_q);
   assign flush    = !tx_reset_done_i || (state_q == ST_WAIT_DONE);
   assign run_ok   = (state_q == ST_RUN) && tx_reset_done_i && !mode_chg;
   assign push     = user_valid_i && user_ready_o && !flush;
   assign pop      = run_ok && (mode_i == MODE_USER) && (level_q != 7'd0);
   assign underrun = run_ok && (mode_i == MODE_USER) && (level_q == 7'd0);

`ifdef TX_PRBS_EN
   // prbs_q holds the 32-bit sequence window being sent this cycle (MSB = oldest bit).
   logic [31:0] prbs_q;

   function automatic logic [31:0] prbs_adv(input logic [31:0] w_in);
      logic [31:0] w;
      w = w_in;
      for (int i = 0; i < 32; i++) w = {w[30:0], w[30] ^ w[27]};
      return w;
   endfunction

   // Seed outside RUN so every SYNC->RUN entry starts from the all-ones state.
   always_ff @(posedge TX_WORDCLK_i or negedge TX_RESET_N_i) begin
      if (!TX_RESET_N_i)                         prbs_q <= {1'b1, 31'h7FFF_FFFF};
      else if (state_q != ST_RUN)                prbs_q <= {1'b1, 31'h7FFF_FFFF};
      else if (run_ok && (mode_i == MODE_PRBS))  prbs_q <= prbs_adv(prbs_q);
   end
`endif

   // State register.
   always_ff @(posedge TX_WORDCLK_i or negedge TX_RESET_N_i) begin
      if (!TX_RESET_N_i) state_q <= ST_WAIT_DONE;
      else               state_q <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state_q;
      if (!tx_reset_done_i) begin
         state_nxt = ST_WAIT_DONE;
      end else begin
         case (state_q)
            ST_WAIT_DONE: if (done_q)               state_nxt = ST_SYNC;
            ST_SYNC:      if (sync_cnt_q <= 8'd1)   state_nxt = ST_RUN;
            ST_RUN:       if (mode_chg)             state_nxt = ST_SYNC;
            default:                                state_nxt = ST_WAIT_DONE;
         endcase
      end
   end

   // Output selection for the registered word and active flag.
   always_comb begin
      data_d   = IDLE_WORD;
      active_d = 1'b0;
      if (tx_reset_done_i) begin
         case (state_q)
            ST_SYNC: data_d = SYNC_WORD;
            ST_RUN: begin
               if (run_ok) begin
                  active_d = 1'b1;
                  case (mode_i)
                     MODE_USER:  data_d = pop ? mem[rd_ptr_q] : IDLE_WORD;
                     MODE_COUNT: data_d = cnt_q;
`ifdef TX_PRBS_EN
                     MODE_PRBS:  data_d = prbs_q;
`else
                     MODE_PRBS:  data_d = IDLE_WORD;
`endif
                     default:    data_d = IDLE_WORD;
                  endcase
               end
            end
            default: data_d = IDLE_WORD;
         endcase
      end
   end

   // FIFO occupancy after this edge; also feeds the registered ready.
   always_comb begin
      level_nxt = level_q;
      if (flush)             level_nxt = 7'd0;
      else if (push && !pop) level_nxt = level_q + 7'd1;
      else if (pop && !push) level_nxt = level_q - 7'd1;
   end

   // Registered outputs plus done/mode history and preamble down-counter.
   always_ff @(posedge TX_WORDCLK_i or negedge TX_RESET_N_i) begin
      if (!TX_RESET_N_i) begin
         USER_DATA_o  <= IDLE_WORD;
         tx_active_o  <= 1'b0;
         user_ready_o <= 1'b0;
         done_q       <= 1'b0;
         mode_q       <= MODE_IDLE;
         sync_cnt_q   <= 8'(SYNC_LEN);
      end else begin
         USER_DATA_o  <= data_d;
         tx_active_o  <= active_d;
         user_ready_o <= (level_nxt != 7'(FIFO_DEPTH)) && (state_nxt != ST_WAIT_DONE);
         done_q       <= tx_reset_done_i;
         mode_q       <= mode_i;
         if (state_q != ST_SYNC) sync_cnt_q <= 8'(SYNC_LEN);
         else                    sync_cnt_q <= sync_cnt_q - 8'd1;
      end
   end

   // Count source restarts from zero on every entry to RUN.
   always_ff @(posedge TX_WORDCLK_i or negedge TX_RESET_N_i) begin
      if (!TX_RESET_N_i)                          cnt_q <= 32'd0;
      else if (state_q != ST_RUN)                 cnt_q <= 32'd0;
      else if (run_ok && (mode_i == MODE_COUNT))  cnt_q <= cnt_q + 32'd1;
   end

   // FIFO pointers and level; wrap is natural since FIFO_DEPTH is a power of 2.
   always_ff @(posedge TX_WORDCLK_i or negedge TX_RESET_N_i) begin
      if (!TX_RESET_N_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= 7'd0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= 7'd0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         level_q <= level_nxt;
      end
   end

   // FIFO storage.
   always_ff @(posedge TX_WORDCLK_i) begin
      if (push) mem[wr_ptr_q] <= user_data_i;
   end

   // Saturating underrun counter, cleared only by reset.
   always_ff @(posedge TX_WORDCLK_i or negedge TX_RESET_N_i) begin
      if (!TX_RESET_N_i)                               underrun_cnt_q <= 16'd0;
      else if (underrun && (underrun_cnt_q != 16'hFFFF)) underrun_cnt_q <= underrun_cnt_q + 16'd1;
   end

   assign fifo_level_o   = level_q;
   assign underrun_cnt_o = underrun_cnt_q;

endmodule
